// File: rtl/jtframe_ram_rq_gen.sv
// SDRAM request channel: turns a level-valid bus strobe into one arbiter request.
// Optional one-entry read cache is built when JTFRAME_RAM_CACHE_EN is defined.
module jtframe_ram_rq_gen #(
  parameter int AW = 18,
  parameter int DW = 8
) (
  input  logic              rst,
  input  logic              clk,
  input  logic [AW-1:0]     addr,
  input  logic [21:0]       offset,
  input  logic              addr_ok,
  input  logic              wrin,
  input  logic [DW-1:0]     wrdata,
  input  logic [DW/8-1:0]   wrmask,
  input  logic [31:0]       din,
  input  logic              din_ok,
  input  logic              we,
  output logic              req,
  output logic              req_rnw,
  output logic [21:0]       sdram_addr,
  output logic [31:0]       sdram_din,
  output logic [3:0]        sdram_wrmask,
  output logic              data_ok,
  output logic [DW-1:0]     dout
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic        last_cs_q, last_cs_d, start_q, start_d, ack_q, ack_d;
  logic [31:0] din_q, din_d;
  logic [21:0] pend_addr_q, pend_addr_d;
  logic [31:0] pend_din_q, pend_din_d;
  logic [3:0]  pend_mask_q, pend_mask_d;
  logic        pend_wr_q, pend_wr_d, pend_lane_q, pend_lane_d;
  logic        pending_q, pending_d, aborted_q, aborted_d;
  logic        wr_q, wr_d, lane_q, lane_d;
  logic        req_q, req_d, req_rnw_q, req_rnw_d, data_ok_q, data_ok_d;
  logic [21:0] sdram_addr_q, sdram_addr_d;
  logic [31:0] sdram_din_q, sdram_din_d;
  logic [3:0]  sdram_wrmask_q, sdram_wrmask_d;
  logic [DW-1:0] dout_q, dout_d;

  logic [21:0] map_addr;
  logic [31:0] map_din;
  logic [3:0]  map_mask;
  logic        map_lane;
  logic [31:0] rd_src;
  logic        rd_lane_sel;
  logic [DW-1:0] rd_data;
  logic        hit, load_rq;

  generate
    if (DW == 8) begin : g_dw8
      assign map_addr    = 22'(addr >> 1) + offset;
      assign map_lane    = addr[0];
      assign map_din     = {4{wrdata}};
      assign map_mask    = addr[0] ? {2'b00, wrmask[0], 1'b0} : {3'b000, wrmask[0]};
      assign rd_data     = rd_lane_sel ? rd_src[15:8] : rd_src[7:0];
    end else if (DW == 16) begin : g_dw16
      assign map_addr    = 22'(addr) + offset;
      assign map_lane    = 1'b0;
      assign map_din     = {2{wrdata}};
      assign map_mask    = {2'b00, wrmask};
      assign rd_data     = rd_src[15:0];
    end else if (DW == 32) begin : g_dw32
      assign map_addr    = 22'({addr, 1'b0}) + offset;
      assign map_lane    = 1'b0;
      assign map_din     = wrdata;
      assign map_mask    = wrmask;
      assign rd_data     = rd_src;
    end else begin : g_bad_dw
      $error("jtframe_ram_rq_gen: DW must be 8, 16 or 32");
    end
  endgenerate

`ifdef JTFRAME_RAM_CACHE_EN
  logic [21:0] ctag_q, ctag_d;
  logic [31:0] cdata_q, cdata_d;
  logic        cvalid_q, cvalid_d;
  // In IDLE the only read source is the cache (hit path); otherwise SDRAM data
  assign rd_src      = (state_q == ST_IDLE) ? cdata_q : din_q;
  assign rd_lane_sel = (state_q == ST_IDLE) ? pend_lane_q : lane_q;
  assign hit         = cvalid_q && !pend_wr_q && (ctag_q == pend_addr_q);
`else
  assign rd_src      = din_q;
  assign rd_lane_sel = lane_q;
  assign hit         = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{rd_src, rd_lane_sel};

  // Handshake: addr_ok is a level valid from the bus; req is held until the
  // arbiter acks with din_ok & we, and data_ok is held until addr_ok falls.
  always_comb begin
    state_d        = state_q;
    last_cs_d      = addr_ok;
    start_d        = addr_ok & ~last_cs_q;
    ack_d          = din_ok & we;
    din_d          = (din_ok & we) ? din : din_q;
    pend_addr_d    = pend_addr_q;
    pend_din_d     = pend_din_q;
    pend_mask_d    = pend_mask_q;
    pend_wr_d      = pend_wr_q;
    pend_lane_d    = pend_lane_q;
    pending_d      = pending_q;
    aborted_d      = aborted_q;
    wr_d           = wr_q;
    lane_d         = lane_q;
    req_d          = req_q;
    req_rnw_d      = req_rnw_q;
    data_ok_d      = data_ok_q;
    sdram_addr_d   = sdram_addr_q;
    sdram_din_d    = sdram_din_q;
    sdram_wrmask_d = sdram_wrmask_q;
    dout_d         = dout_q;
    load_rq        = 1'b0;
`ifdef JTFRAME_RAM_CACHE_EN
    ctag_d         = ctag_q;
    cdata_d        = cdata_q;
    cvalid_d       = cvalid_q;
`endif

    if (addr_ok && !last_cs_q) begin
      pend_addr_d = map_addr;
      pend_din_d  = map_din;
      pend_mask_d = map_mask;
      pend_wr_d   = wrin;
      pend_lane_d = map_lane;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_q) begin
          if (hit) begin
            if (addr_ok) begin
              state_d   = ST_DONE;
              data_ok_d = 1'b1;
              dout_d    = rd_data;
            end
          end else begin
            load_rq = 1'b1;
          end
        end
      end
      ST_REQ: begin
        aborted_d = aborted_q | ~addr_ok;
        if (start_q) pending_d = 1'b1;
        if (ack_q) begin
`ifdef JTFRAME_RAM_CACHE_EN
          if (!wr_q) begin
            ctag_d   = sdram_addr_q;
            cdata_d  = din_q;
            cvalid_d = 1'b1;
          end else if (ctag_q == sdram_addr_q) begin
            cvalid_d = 1'b0;
          end
`endif
          if (pending_q || start_q) begin
            load_rq = 1'b1;
          end else begin
            req_d     = 1'b0;
            req_rnw_d = 1'b1;
            if (aborted_q || !addr_ok) begin
              state_d = ST_IDLE;
            end else begin
              state_d   = ST_DONE;
              data_ok_d = 1'b1;
              if (!wr_q) dout_d = rd_data;
            end
          end
        end
      end
      ST_DONE: begin
        if (!addr_ok) begin
          state_d   = ST_IDLE;
          data_ok_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_rq) begin
      state_d        = ST_REQ;
      req_d          = 1'b1;
      req_rnw_d      = ~pend_wr_q;
      sdram_addr_d   = pend_addr_q;
      sdram_din_d    = pend_din_q;
      sdram_wrmask_d = pend_wr_q ? pend_mask_q : 4'd0;
      wr_d           = pend_wr_q;
      lane_d         = pend_lane_q;
      pending_d      = 1'b0;
      aborted_d      = ~addr_ok;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      last_cs_q      <= 1'b0;
      start_q        <= 1'b0;
      ack_q          <= 1'b0;
      din_q          <= '0;
      pend_addr_q    <= '0;
      pend_din_q     <= '0;
      pend_mask_q    <= '0;
      pend_wr_q      <= 1'b0;
      pend_lane_q    <= 1'b0;
      pending_q      <= 1'b0;
      aborted_q      <= 1'b0;
      wr_q           <= 1'b0;
      lane_q         <= 1'b0;
      req_q          <= 1'b0;
      req_rnw_q      <= 1'b1;
      data_ok_q      <= 1'b0;
      sdram_addr_q   <= '0;
      sdram_din_q    <= '0;
      sdram_wrmask_q <= '0;
      dout_q         <= '0;
    end else begin
      state_q        <= state_d;
      last_cs_q      <= last_cs_d;
      start_q        <= start_d;
      ack_q          <= ack_d;
      din_q          <= din_d;
      pend_addr_q    <= pend_addr_d;
      pend_din_q     <= pend_din_d;
      pend_mask_q    <= pend_mask_d;
      pend_wr_q      <= pend_wr_d;
      pend_lane_q    <= pend_lane_d;
      pending_q      <= pending_d;
      aborted_q      <= aborted_d;
      wr_q           <= wr_d;
      lane_q         <= lane_d;
      req_q          <= req_d;
      req_rnw_q      <= req_rnw_d;
      data_ok_q      <= data_ok_d;
      sdram_addr_q   <= sdram_addr_d;
      sdram_din_q    <= sdram_din_d;
      sdram_wrmask_q <= sdram_wrmask_d;
      dout_q         <= dout_d;
    end
  end

`ifdef JTFRAME_RAM_CACHE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctag_q   <= '0;
      cdata_q  <= '0;
      cvalid_q <= 1'b0;
    end else begin
      ctag_q   <= ctag_d;
      cdata_q  <= cdata_d;
      cvalid_q <= cvalid_d;
    end
  end
`endif

  assign req          = req_q;
  assign req_rnw      = req_rnw_q;
  assign data_ok      = data_ok_q;
  assign dout         = dout_q;
  assign sdram_addr   = sdram_addr_q;
  assign sdram_din    = sdram_din_q;
  assign sdram_wrmask = sdram_wrmask_q;

endmodule

// File: tb/tb_jtframe_ram_rq_gen.sv
// Bench for jtframe_ram_rq_gen: DW=8 vector table plus DW=16 multi-cycle sequences.
module tb_jtframe_ram_rq_gen;

  logic clk, rst;

  // DW=8 instance signals
  logic [17:0] addr8;
  logic [21:0] offset8;
  logic        addr_ok8, wrin8, din_ok8, we8;
  logic [7:0]  wrdata8;
  logic [0:0]  wrmask8;
  logic [31:0] din8;
  logic        req8, req_rnw8, data_ok8;
  logic [21:0] sdram_addr8;
  logic [31:0] sdram_din8;
  logic [3:0]  sdram_wrmask8;
  logic [7:0]  dout8;

  // DW=16 instance signals
  logic [17:0] addr16;
  logic [21:0] offset16;
  logic        addr_ok16, wrin16, din_ok16, we16;
  logic [15:0] wrdata16;
  logic [1:0]  wrmask16;
  logic [31:0] din16;
  logic        req16, req_rnw16, data_ok16;
  logic [21:0] sdram_addr16;
  logic [31:0] sdram_din16;
  logic [3:0]  sdram_wrmask16;
  logic [15:0] dout16;

  int checks = 0;
  int errors = 0;

  jtframe_ram_rq_gen #(.AW(18), .DW(8)) u8 (
    .rst(rst), .clk(clk), .addr(addr8), .offset(offset8), .addr_ok(addr_ok8),
    .wrin(wrin8), .wrdata(wrdata8), .wrmask(wrmask8), .din(din8), .din_ok(din_ok8),
    .we(we8), .req(req8), .req_rnw(req_rnw8), .sdram_addr(sdram_addr8),
    .sdram_din(sdram_din8), .sdram_wrmask(sdram_wrmask8), .data_ok(data_ok8), .dout(dout8)
  );

  jtframe_ram_rq_gen #(.AW(18), .DW(16)) u16 (
    .rst(rst), .clk(clk), .addr(addr16), .offset(offset16), .addr_ok(addr_ok16),
    .wrin(wrin16), .wrdata(wrdata16), .wrmask(wrmask16), .din(din16), .din_ok(din_ok16),
    .we(we16), .req(req16), .req_rnw(req_rnw16), .sdram_addr(sdram_addr16),
    .sdram_din(sdram_din16), .sdram_wrmask(sdram_wrmask16), .data_ok(data_ok16), .dout(dout16)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] offset;
    logic [17:0] addr;
    logic        wr;
    logic [7:0]  wrdata;
    logic        wrmask;
    logic [31:0] din;
    logic [21:0] exp_addr;
    logic [31:0] exp_din;
    logic [3:0]  exp_mask;
    logic [7:0]  exp_dout;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full DW=8 operation; exp_hit selects the cached (no request) path
  task automatic op8(input vec_t v, input bit exp_hit);
    int n;
    bit seen_req;
    offset8 = v.offset; addr8 = v.addr; wrin8 = v.wr;
    wrdata8 = v.wrdata; wrmask8 = v.wrmask; addr_ok8 = 1'b1;
    n = 0; seen_req = 1'b0;
    do begin
      @(negedge clk); n++;
      if (req8) seen_req = 1'b1;
    end while (!req8 && !data_ok8 && n < 10);
    if (exp_hit) begin
      check("hit_no_req", 32'(seen_req), 32'd0);
      check("hit_latency", 32'(n), 32'd2);
      check("hit_data_ok", 32'(data_ok8), 32'd1);
      check("hit_dout", 32'(dout8), 32'(v.exp_dout));
    end else begin
      check("req_latency", 32'(n), 32'd2);
      check("req", 32'(req8), 32'd1);
      check("req_rnw", 32'(req_rnw8), 32'(!v.wr));
      check("sdram_addr", 32'(sdram_addr8), 32'(v.exp_addr));
      if (v.wr) begin
        check("sdram_din", sdram_din8, v.exp_din);
        check("sdram_wrmask", 32'(sdram_wrmask8), 32'(v.exp_mask));
      end
      din8 = v.din; din_ok8 = 1'b1; we8 = 1'b1;
      n = 0;
      do begin
        @(negedge clk); n++;
        din_ok8 = 1'b0; we8 = 1'b0;
      end while (!data_ok8 && n < 10);
      check("ack_latency", 32'(n), 32'd2);
      check("req_after_ack", 32'(req8), 32'd0);
      check("rnw_after_ack", 32'(req_rnw8), 32'd1);
      if (!v.wr) check("dout", 32'(dout8), 32'(v.exp_dout));
    end
    addr_ok8 = 1'b0;
    @(negedge clk);
    check("data_ok_fall", 32'(data_ok8), 32'd0);
  endtask

  task automatic wait16(input bit want_req, output int n);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(want_req ? req16 : data_ok16) && n < 10);
    if (n >= 10) check(want_req ? "req16_timeout" : "data_ok16_timeout", 32'(n), 32'd0);
  endtask

  task automatic ack16(input logic [31:0] d);
    din16 = d; din_ok16 = 1'b1; we16 = 1'b1;
    @(negedge clk);
    din_ok16 = 1'b0; we16 = 1'b0;
  endtask

  initial begin
    int n;
    bit seen;
    vec_t v;

    vecs[0] = '{22'h100,    18'h00005, 1'b0, 8'h00, 1'b0, 32'h0000AB12, 22'h102,   32'h0,        4'h0,    8'hAB};
    vecs[1] = '{22'h100,    18'h00010, 1'b0, 8'h00, 1'b0, 32'h5A5A3C7E, 22'h108,   32'h0,        4'h0,    8'h7E};
    vecs[2] = '{22'h100,    18'h00007, 1'b1, 8'hC3, 1'b1, 32'h0,        22'h103,   32'hC3C3C3C3, 4'b0010, 8'h00};
    vecs[3] = '{22'h100,    18'h00008, 1'b1, 8'h99, 1'b1, 32'h0,        22'h104,   32'h99999999, 4'b0001, 8'h00};
    vecs[4] = '{22'h100,    18'h00009, 1'b1, 8'h5D, 1'b0, 32'h0,        22'h104,   32'h5D5D5D5D, 4'b0000, 8'h00};
    vecs[5] = '{22'h100,    18'h3FFFF, 1'b0, 8'h00, 1'b0, 32'h12345678, 22'h200FF, 32'h0,        4'h0,    8'h56};
    vecs[6] = '{22'h3FFFFF, 18'h00004, 1'b0, 8'h00, 1'b0, 32'h000000EE, 22'h000001, 32'h0,       4'h0,    8'hEE};

    rst = 1'b1;
    addr8 = '0; offset8 = '0; addr_ok8 = 1'b0; wrin8 = 1'b0; wrdata8 = '0; wrmask8 = '0;
    din8 = '0; din_ok8 = 1'b0; we8 = 1'b0;
    addr16 = '0; offset16 = 22'h100; addr_ok16 = 1'b0; wrin16 = 1'b0; wrdata16 = '0;
    wrmask16 = '0; din16 = '0; din_ok16 = 1'b0; we16 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_req", 32'(req8), 32'd0);
    check("rst_req_rnw", 32'(req_rnw8), 32'd1);
    check("rst_data_ok", 32'(data_ok8), 32'd0);
    check("rst_dout", 32'(dout8), 32'd0);
    check("rst_sdram_addr", 32'(sdram_addr8), 32'd0);
    check("rst_sdram_din", sdram_din8, 32'd0);
    check("rst_sdram_wrmask", 32'(sdram_wrmask8), 32'd0);

    for (int i = 0; i < 7; i++) op8(vecs[i], 1'b0);

    // din_ok without grant must be ignored
    addr8 = 18'h00020; offset8 = 22'h100; wrin8 = 1'b0; addr_ok8 = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req8 && n < 10);
    check("nogrant_req_addr", 32'(sdram_addr8), 32'h110);
    din8 = 32'hDEAD0000; din_ok8 = 1'b1; we8 = 1'b0; seen = 1'b0;
    repeat (3) begin @(negedge clk); if (data_ok8) seen = 1'b1; end
    din_ok8 = 1'b0;
    check("nogrant_data_ok", 32'(seen), 32'd0);
    check("nogrant_req_held", 32'(req8), 32'd1);
    din8 = 32'h000000A5; din_ok8 = 1'b1; we8 = 1'b1;
    @(negedge clk); din_ok8 = 1'b0; we8 = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!data_ok8 && n < 10);
    check("nogrant_dout", 32'(dout8), 32'hA5);
    addr_ok8 = 1'b0;
    @(negedge clk);

    // repeated read, then write and read of the same address
    v = '{22'h100, 18'h00040, 1'b0, 8'h00, 1'b0, 32'h00006789, 22'h120, 32'h0, 4'h0, 8'h89};
    op8(v, 1'b0);
`ifdef JTFRAME_RAM_CACHE_EN
    op8(v, 1'b1);
`else
    op8(v, 1'b0);
`endif
    op8('{22'h100, 18'h00040, 1'b1, 8'h11, 1'b1, 32'h0, 22'h120, 32'h11111111, 4'b0001, 8'h00}, 1'b0);
    op8('{22'h100, 18'h00040, 1'b0, 8'h00, 1'b0, 32'h00000055, 22'h120, 32'h0, 4'h0, 8'h55}, 1'b0);

    // DW=16 write
    addr16 = 18'h10; wrin16 = 1'b1; wrdata16 = 16'h1234; wrmask16 = 2'b10; addr_ok16 = 1'b1;
    wait16(1'b1, n);
    check("w16_req_rnw", 32'(req_rnw16), 32'd0);
    check("w16_sdram_addr", 32'(sdram_addr16), 32'h110);
    check("w16_sdram_din", sdram_din16, 32'h12341234);
    check("w16_sdram_wrmask", 32'(sdram_wrmask16), 32'b0010);
    ack16(32'h0);
    check("w16_data_ok_early", 32'(data_ok16), 32'd0);
    @(negedge clk);
    check("w16_data_ok", 32'(data_ok16), 32'd1);
    check("w16_req_low", 32'(req16), 32'd0);
    addr_ok16 = 1'b0;
    @(negedge clk);

    // abort: addr_ok drops while the request is outstanding
    addr16 = 18'h30; wrin16 = 1'b0; addr_ok16 = 1'b1;
    wait16(1'b1, n);
    addr_ok16 = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_req_held", 32'(req16), 32'd1);
    ack16(32'h0000BEEF);
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (data_ok16) seen = 1'b1; end
    check("abort_data_ok", 32'(seen), 32'd0);
    check("abort_req_low", 32'(req16), 32'd0);
    addr16 = 18'h31; addr_ok16 = 1'b1;
    wait16(1'b1, n);
    check("after_abort_addr", 32'(sdram_addr16), 32'h131);
    ack16(32'h00004444);
    wait16(1'b0, n);
    check("after_abort_dout", 32'(dout16), 32'h4444);
    addr_ok16 = 1'b0;
    @(negedge clk);

    // queue: new start while the first request is outstanding
    addr16 = 18'h18; addr_ok16 = 1'b1;
    wait16(1'b1, n);
    check("q_first_addr", 32'(sdram_addr16), 32'h118);
    addr_ok16 = 1'b0;
    @(negedge clk);
    addr16 = 18'h20; addr_ok16 = 1'b1;
    repeat (2) @(negedge clk);
    seen = 1'b0;
    ack16(32'h00001111);
    if (data_ok16) seen = 1'b1;
    @(negedge clk);
    if (data_ok16) seen = 1'b1;
    check("q_req_kept", 32'(req16), 32'd1);
    check("q_second_addr", 32'(sdram_addr16), 32'h120);
    check("q_no_data_ok", 32'(seen), 32'd0);
    ack16(32'h00002222);
    wait16(1'b0, n);
    check("q_second_dout", 32'(dout16), 32'h2222);
    addr_ok16 = 1'b0;
    @(negedge clk);

    // reset in the middle of a request
    addr8 = 18'h00050; offset8 = 22'h100; wrin8 = 1'b0; addr_ok8 = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req8 && n < 10);
    check("midrst_req_before", 32'(req8), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_req", 32'(req8), 32'd0);
    check("midrst_req_rnw", 32'(req_rnw8), 32'd1);
    check("midrst_sdram_addr", 32'(sdram_addr8), 32'd0);
    addr_ok8 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_stays_idle", 32'(req8), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
